// File: rtl/doa_scan_ctrl.sv
// DoA scan sequencer and peak picker for the 4-channel beamformer power block.
// Optional per-bin spectrum outputs are enabled with DOA_SPECTRUM_OUT_EN.
module doa_scan_ctrl #(
  parameter int WORD_LENGTH_IN  = 16,
  parameter int WORD_LENGTH_POW = 32,
  parameter int N_ANGLES        = 181,
  parameter int ROM_LATENCY     = 1,
  parameter int ADDR_W          = $clog2(N_ANGLES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [8*WORD_LENGTH_IN-1:0] in_iq,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [8*WORD_LENGTH_IN-1:0] x_hold,
  output logic [ADDR_W-1:0]           steer_addr,
  input  logic [WORD_LENGTH_POW-1:0]  pow_in,
  output logic [ADDR_W-1:0]           peak_idx,
  output logic [WORD_LENGTH_POW-1:0]  peak_pow,
  output logic                        out_valid,
  input  logic                        out_ready
`ifdef DOA_SPECTRUM_OUT_EN
  ,
  output logic                        spec_valid,
  output logic [ADDR_W-1:0]           spec_idx,
  output logic [WORD_LENGTH_POW-1:0]  spec_pow
`endif
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_ANGLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  state_t state;

  logic              issue_v;
  logic              tag_v;
  logic [ADDR_W-1:0] tag_i;
  logic              first;
  logic              last_seen;

  assign issue_v = (state == SCAN);

  // Tag travels with each address so pow_in is matched to its bin.
  generate
    if (ROM_LATENCY == 0) begin : g_nopipe
      assign tag_v = issue_v;
      assign tag_i = steer_addr;
    end else begin : g_pipe
      logic [ROM_LATENCY-1:0] pv;
      logic [ADDR_W-1:0]      pi [ROM_LATENCY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pv <= '0;
          for (int k = 0; k < ROM_LATENCY; k++) pi[k] <= '0;
        end else begin
          pv[0] <= issue_v;
          pi[0] <= steer_addr;
          for (int k = 1; k < ROM_LATENCY; k++) begin
            pv[k] <= pv[k-1];
            pi[k] <= pi[k-1];
          end
        end
      end

      assign tag_v = pv[ROM_LATENCY-1];
      assign tag_i = pi[ROM_LATENCY-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      x_hold     <= '0;
      steer_addr <= '0;
      peak_idx   <= '0;
      peak_pow   <= '0;
      out_valid  <= 1'b0;
      first      <= 1'b0;
      last_seen  <= 1'b0;
    end else begin
      // First sample always loads, so ties keep the lowest index.
      if (tag_v) begin
        if (first || (pow_in > peak_pow)) begin
          peak_pow <= pow_in;
          peak_idx <= tag_i;
        end
        first <= 1'b0;
        if (tag_i == LAST) last_seen <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            x_hold     <= in_iq;
            peak_pow   <= '0;
            peak_idx   <= '0;
            first      <= 1'b1;
            last_seen  <= 1'b0;
            steer_addr <= '0;
            in_ready   <= 1'b0;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (steer_addr == LAST) begin
            steer_addr <= '0;
            state      <= DRAIN;
          end else begin
            steer_addr <= steer_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (last_seen) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DOA_SPECTRUM_OUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spec_valid <= 1'b0;
      spec_idx   <= '0;
      spec_pow   <= '0;
    end else begin
      spec_valid <= tag_v;
      if (tag_v) begin
        spec_idx <= tag_i;
        spec_pow <= pow_in;
      end
    end
  end
`endif

endmodule

// File: tb/tb_doa_scan_ctrl.sv
// Scoreboard bench for doa_scan_ctrl at ROM latencies 1, 0 and 4.
// Spectrum checks are compiled in with DOA_SPECTRUM_OUT_EN.
module tb_doa_scan_ctrl;

  localparam int N  = 181;
  localparam int W  = 16;
  localparam int P  = 32;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           iv   [3];
  logic           ir   [3];
  logic           ov   [3];
  logic           ordy [3];
  logic [8*W-1:0] iq   [3];
  logic [8*W-1:0] xh   [3];
  logic [AW-1:0]  sa   [3];
  logic [AW-1:0]  pidx [3];
  logic [P-1:0]   pw   [3];
  logic [P-1:0]   ppow [3];
`ifdef DOA_SPECTRUM_OUT_EN
  logic           sv   [3];
  logic [AW-1:0]  si   [3];
  logic [P-1:0]   sp   [3];
`endif

  logic [P-1:0]  tab [N];
  logic [AW-1:0] d1;
  logic [AW-1:0] d4 [4];

  // ROM models: power for an address appears ROM_LATENCY cycles later.
  always @(posedge clk) begin
    d1    <= sa[0];
    d4[0] <= sa[2];
    for (int k = 1; k < 4; k++) d4[k] <= d4[k-1];
  end

  assign pw[0] = tab[d1];
  assign pw[1] = tab[sa[1]];
  assign pw[2] = tab[d4[3]];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    doa_scan_ctrl #(
      .WORD_LENGTH_IN (W),
      .WORD_LENGTH_POW(P),
      .N_ANGLES       (N),
      .ROM_LATENCY    (g == 0 ? 1 : (g == 1 ? 0 : 4))
    ) u (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_iq     (iq[g]),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .x_hold    (xh[g]),
      .steer_addr(sa[g]),
      .pow_in    (pw[g]),
      .peak_idx  (pidx[g]),
      .peak_pow  (ppow[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g])
`ifdef DOA_SPECTRUM_OUT_EN
      ,
      .spec_valid(sv[g]),
      .spec_idx  (si[g]),
      .spec_pow  (sp[g])
`endif
    );
  end

  typedef struct {
    logic [AW-1:0]  idx;
    logic [P-1:0]   pow;
    int             lat;
    logic [8*W-1:0] x;
  } exp_t;

  exp_t sb [$];
  int   tests = 0;
  int   fails = 0;
  int   acc [3];
  int   sp_n = 0;

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 4);
  endfunction

`ifdef DOA_SPECTRUM_OUT_EN
  always @(negedge clk) begin
    if (sv[0] === 1'b1) begin
      tests++;
      if (si[0] !== AW'(sp_n) || sp[0] !== tab[sp_n]) begin
        fails++;
        $display("FAIL spec_pulse got idx=%0d pow=%0h want idx=%0d pow=%0h",
                 si[0], sp[0], sp_n, tab[sp_n]);
      end
      sp_n++;
    end
  end
`endif

  function automatic logic [8*W-1:0] rnd_iq();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic start(int d, logic [8*W-1:0] x);
    exp_t e;
    int bi;
    logic [P-1:0] bp;
    int t;
    bi = 0;
    bp = tab[0];
    for (int i = 1; i < N; i++)
      if (tab[i] > bp) begin
        bp = tab[i];
        bi = i;
      end
    e.idx = AW'(bi);
    e.pow = bp;
    e.lat = N + lat_of(d) + 1;
    e.x   = x;
    sb.push_back(e);
    iv[d] = 1'b1;
    iq[d] = x;
    t = 0;
    while (ir[d] !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (ir[d] !== 1'b1) begin
      fails++;
      $display("FAIL accept_timeout d=%0d in_ready=%b want 1", d, ir[d]);
    end
    @(negedge clk);
    acc[d] = cyc;
    iv[d]  = 1'b0;
    if (d == 0) sp_n = 0;
    tests++;
    if (xh[d] !== x) begin
      fails++;
      $display("FAIL x_hold d=%0d got %0h want %0h", d, xh[d], x);
    end
  endtask

  task automatic finish(int d, int hold, bit pend, logic [8*W-1:0] px);
    exp_t e;
    int t;
    ordy[d] = (hold == 0);
    t = 0;
    while (ov[d] !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    e = sb.pop_front();
    tests++;
    if (ov[d] !== 1'b1) begin
      fails++;
      $display("FAIL result_timeout d=%0d out_valid=%b want 1", d, ov[d]);
    end else begin
      tests++;
      if (cyc - acc[d] != e.lat) begin
        fails++;
        $display("FAIL latency d=%0d got %0d want %0d", d, cyc - acc[d], e.lat);
      end
      tests++;
      if (pidx[d] !== e.idx) begin
        fails++;
        $display("FAIL peak_idx d=%0d got %0d want %0d", d, pidx[d], e.idx);
      end
      tests++;
      if (ppow[d] !== e.pow) begin
        fails++;
        $display("FAIL peak_pow d=%0d got %0h want %0h", d, ppow[d], e.pow);
      end
    end
    if (hold > 0) begin
      if (pend) begin
        iv[d] = 1'b1;
        iq[d] = px;
      end
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        tests++;
        if (ov[d] !== 1'b1 || pidx[d] !== e.idx || ppow[d] !== e.pow ||
            ir[d] !== 1'b0 || xh[d] !== e.x) begin
          fails++;
          $display("FAIL bp_stable d=%0d got v=%b i=%0d p=%0h r=%b want v=1 i=%0d p=%0h r=0",
                   d, ov[d], pidx[d], ppow[d], ir[d], e.idx, e.pow);
        end
      end
      ordy[d] = 1'b1;
    end
    @(negedge clk);
    tests++;
    if (ov[d] !== 1'b0 || ir[d] !== 1'b1) begin
      fails++;
      $display("FAIL handshake d=%0d got v=%b r=%b want v=0 r=1", d, ov[d], ir[d]);
    end
  endtask

  task automatic check_idle(string nm);
    for (int d = 0; d < 3; d++) begin
      tests++;
      if (ir[d] !== 1'b1 || ov[d] !== 1'b0 || sa[d] !== '0 ||
          pidx[d] !== '0 || ppow[d] !== '0 || xh[d] !== '0) begin
        fails++;
        $display("FAIL %s d=%0d got r=%b v=%b a=%0d i=%0d p=%0h x=%0h want r=1 rest 0",
                 nm, d, ir[d], ov[d], sa[d], pidx[d], ppow[d], xh[d]);
      end
`ifdef DOA_SPECTRUM_OUT_EN
      tests++;
      if (sv[d] !== 1'b0 || si[d] !== '0 || sp[d] !== '0) begin
        fails++;
        $display("FAIL %s_spec d=%0d got v=%b i=%0d p=%0h want 0", nm, d, sv[d], si[d], sp[d]);
      end
`endif
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int t;
    int bad;
    for (int i = 0; i < N; i++) tab[i] = 32'd7;
    start(0, rnd_iq());
    void'(sb.pop_back());
    t = 0;
    while (sa[0] !== AW'(50) && t < 400) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (sa[0] !== AW'(50)) begin
      fails++;
      $display("FAIL mid_addr got %0d want 50", sa[0]);
    end
    rst_n = 1'b0;
    #1;
    check_idle("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) if (ov[d] !== 1'b0 || ir[d] !== 1'b1) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL post_reset_quiet got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_single_peak();
    for (int i = 0; i < N; i++) tab[i] = 32'd10;
    tab[73] = 32'd1000;
    start(0, rnd_iq());
    finish(0, 0, 1'b0, '0);
  endtask

  task automatic test_ties_bounds();
    for (int i = 0; i < N; i++) tab[i] = '0;
    tab[0]   = 32'hFFFF_FFFF;
    tab[180] = 32'hFFFF_FFFF;
    start(0, rnd_iq());
    finish(0, 0, 1'b0, '0);
    for (int i = 0; i < N; i++) tab[i] = '0;
    tab[180] = 32'd5;
    start(0, rnd_iq());
    finish(0, 0, 1'b0, '0);
    for (int i = 0; i < N; i++) tab[i] = '0;
    start(0, rnd_iq());
    finish(0, 0, 1'b0, '0);
  endtask

  task automatic test_backpressure();
    logic [8*W-1:0] nx;
    nx = rnd_iq();
    for (int i = 0; i < N; i++) tab[i] = N - i;
    tab[99] = 32'h1234_5678;
    start(0, rnd_iq());
    finish(0, 20, 1'b1, nx);
    for (int i = 0; i < N; i++) tab[i] = 32'd3;
    tab[140] = 32'd4;
    start(0, nx);
    finish(0, 0, 1'b0, '0);
  endtask

  task automatic test_latency_sweep();
    for (int i = 0; i < N; i++) tab[i] = 32'd10;
    tab[1] = 32'd500;
    start(1, rnd_iq());
    finish(1, 0, 1'b0, '0);
    start(2, rnd_iq());
    finish(2, 0, 1'b0, '0);
  endtask

`ifdef DOA_SPECTRUM_OUT_EN
  task automatic test_spectrum();
    for (int i = 0; i < N; i++) tab[i] = i;
    start(0, rnd_iq());
    finish(0, 0, 1'b0, '0);
    tests++;
    if (sp_n != N) begin
      fails++;
      $display("FAIL spec_count got %0d want %0d", sp_n, N);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      iv[d]   = 1'b0;
      ordy[d] = 1'b1;
      iq[d]   = '0;
    end
    for (int i = 0; i < N; i++) tab[i] = '0;
    test_reset();
    test_mid_reset();
    test_single_peak();
    test_ties_bounds();
    test_backpressure();
    test_latency_sweep();
`ifdef DOA_SPECTRUM_OUT_EN
    test_spectrum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
